// File: rtl/sprite_motion_sched.sv
// Per-frame sprite motion scheduler with a lowest-index-wins pixel mixer.
// Define SPRITE_OVERLAP_EN to build the sticky sprite-overlap flag on overlap_o.
module sprite_motion_sched #(
  parameter int unsigned N_OBJ    = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SIZE     = 4,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] row_i,
  input  logic [15:0] column_i,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_idx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_x_i,
  input  logic [15:0] cfg_y_i,
  input  logic [3:0]  cfg_dx_i,
  input  logic [3:0]  cfg_dy_i,
  input  logic [15:0] cfg_color_i,
  output logic        cfg_ready_o,
  output logic        busy_o,
  output logic [15:0] rgb_o,
  output logic [15:0] frame_cnt_o,
  output logic        overlap_o
);

  localparam int unsigned IdxW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [15:0] XMax = 16'(H_ACTIVE - SIZE);
  localparam logic [15:0] YMax = 16'(V_ACTIVE - SIZE);

  typedef enum logic [1:0] {StIdle, StCalc, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       nx_q, ny_q;
  logic              fs_cond, fs_cond_q, fs;
  logic [15:0]       frame_cnt_q;
  logic [15:0]       rgb_q, rgb_d;
  logic              cfg_accept;
  logic              x_bounce, y_bounce;
  logic [N_OBJ-1:0]  hit;

  logic              en_q    [N_OBJ];
  logic [15:0]       x_q     [N_OBJ];
  logic [15:0]       y_q     [N_OBJ];
  logic [3:0]        dx_q    [N_OBJ];
  logic [3:0]        dy_q    [N_OBJ];
  logic [15:0]       color_q [N_OBJ];

  // Edge-detect so a column held by a slow pixel enable yields one pulse.
  assign fs_cond    = (row_i == 16'(V_ACTIVE)) && (column_i == 16'd0);
  assign fs         = fs_cond && !fs_cond_q;
  assign cfg_accept = cfg_we_i && cfg_ready_o;
  assign x_bounce   = nx_q[15] || (nx_q > XMax);
  assign y_bounce   = ny_q[15] || (ny_q > YMax);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (fs) begin
          state_d = StCalc;
          idx_d   = '0;
        end
      end
      StCalc:  state_d = StWrite;
      StWrite: begin
        if (idx_q == IdxW'(N_OBJ - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StCalc;
          idx_d   = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      fs_cond_q   <= 1'b0;
      frame_cnt_q <= '0;
      rgb_q       <= BG_COLOR;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fs_cond_q <= fs_cond;
      rgb_q     <= rgb_d;
      if (fs) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == StCalc) begin
        nx_q <= x_q[idx_q] + {{12{dx_q[idx_q][3]}}, dx_q[idx_q]};
        ny_q <= y_q[idx_q] + {{12{dy_q[idx_q][3]}}, dy_q[idx_q]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N_OBJ); i++) begin
        en_q[i]    <= 1'b0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dx_q[i]    <= '0;
        dy_q[i]    <= '0;
        color_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_OBJ); i++) begin
        if (cfg_accept && (cfg_idx_i == 3'(i))) begin
          en_q[i]    <= cfg_en_i;
          x_q[i]     <= cfg_x_i;
          y_q[i]     <= cfg_y_i;
          dx_q[i]    <= cfg_dx_i;
          dy_q[i]    <= cfg_dy_i;
          color_q[i] <= cfg_color_i;
        end else if ((state_q == StWrite) && (idx_q == IdxW'(i)) && en_q[i]) begin
          if (x_bounce) dx_q[i] <= -dx_q[i];
          else          x_q[i]  <= nx_q;
          if (y_bounce) dy_q[i] <= -dy_q[i];
          else          y_q[i]  <= ny_q;
        end
      end
    end
  end

  // 17-bit compares keep x+SIZE from wrapping near the top of the range.
  always_comb begin
    hit   = '0;
    rgb_d = BG_COLOR;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      hit[i] = en_q[i]
            && ({1'b0, column_i} >= {1'b0, x_q[i]})
            && ({1'b0, column_i} <  ({1'b0, x_q[i]} + 17'(SIZE)))
            && ({1'b0, row_i}    >= {1'b0, y_q[i]})
            && ({1'b0, row_i}    <  ({1'b0, y_q[i]} + 17'(SIZE)));
    end
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (hit[i]) rgb_d = color_q[i];
    end
  end

`ifdef SPRITE_OVERLAP_EN
  logic overlap_q;
  logic active;
  logic multi_hit;

  assign active    = (row_i < 16'(V_ACTIVE)) && (column_i < 16'(H_ACTIVE));
  assign multi_hit = |(hit & (hit - N_OBJ'(1)));

  always_ff @(posedge clk_i) begin
    if (reset_i)                  overlap_q <= 1'b0;
    else if (fs)                  overlap_q <= 1'b0;
    else if (active && multi_hit) overlap_q <= 1'b1;
  end

  assign overlap_o = overlap_q;
`else
  assign overlap_o = 1'b0;
`endif

  assign cfg_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rgb_o       = rgb_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
